// File: rtl/morse_pkg.sv
// Shared Morse definitions: symbol encoding, letter table, encoder state codes.
// No logic of its own; latency n/a.
// Backpressure n/a.
package morse_pkg;

    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_LINE = 1'b1;

    localparam logic [4:0] LETTER_MAX = 5'd25;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MARK = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_LGAP = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // pat is sent from pat[len-1] down to pat[0]; bit 1 = line, 0 = dot.
    typedef struct packed {
        logic [2:0] len;
        logic [3:0] pat;
    } letter_code_t;

    function automatic letter_code_t letter_code(input logic [4:0] idx);
        letter_code_t c;
        c = '0;
        case (idx)
            5'd0:  c = {3'd2, 4'b0001}; // A .-
            5'd1:  c = {3'd4, 4'b1000}; // B -...
            5'd2:  c = {3'd4, 4'b1010}; // C -.-.
            5'd3:  c = {3'd3, 4'b0100}; // D -..
            5'd4:  c = {3'd1, 4'b0000}; // E .
            5'd5:  c = {3'd4, 4'b0010}; // F ..-.
            5'd6:  c = {3'd3, 4'b0110}; // G --.
            5'd7:  c = {3'd4, 4'b0000}; // H ....
            5'd8:  c = {3'd2, 4'b0000}; // I ..
            5'd9:  c = {3'd4, 4'b0111}; // J .---
            5'd10: c = {3'd3, 4'b0101}; // K -.-
            5'd11: c = {3'd4, 4'b0100}; // L .-..
            5'd12: c = {3'd2, 4'b0011}; // M --
            5'd13: c = {3'd2, 4'b0010}; // N -.
            5'd14: c = {3'd3, 4'b0111}; // O ---
            5'd15: c = {3'd4, 4'b0110}; // P .--.
            5'd16: c = {3'd4, 4'b1101}; // Q --.-
            5'd17: c = {3'd3, 4'b0010}; // R .-.
            5'd18: c = {3'd3, 4'b0000}; // S ...
            5'd19: c = {3'd1, 4'b0001}; // T -
            5'd20: c = {3'd3, 4'b0001}; // U ..-
            5'd21: c = {3'd4, 4'b0001}; // V ...-
            5'd22: c = {3'd3, 4'b0011}; // W .--
            5'd23: c = {3'd4, 4'b1001}; // X -..-
            5'd24: c = {3'd4, 4'b1011}; // Y -.--
            5'd25: c = {3'd4, 4'b1100}; // Z --..
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Down-counter measuring 1 or 3 Morse units; expire is high while the count is 0.
// Latency: expire asserts in the last cycle of the loaded interval.
// Backpressure: none; load restarts the interval, clear forces it to 0.
module morse_unit_timer #(
    parameter int UNIT_CYCLES = 25000000
) (
    input  logic clock,
    input  logic resetn,
    input  logic load,
    input  logic long_unit,
    input  logic clear,
    output logic expire
);

    localparam int CW = $clog2(3 * UNIT_CYCLES + 1);
    localparam logic [CW-1:0] LD_SHORT = CW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] LD_LONG  = CW'(3 * UNIT_CYCLES - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clock) begin
        if (!resetn || clear) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= long_unit ? LD_LONG : LD_SHORT;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expire = (count_q == '0);

endmodule

// File: rtl/morse_encoder.sv
// Plays one letter as on/off keying with dot/line strobes and a done pulse.
// Latency: first mark cycle follows the accept edge; done one cycle after the letter gap.
// Backpressure: ready only in idle; start without ready is dropped, cancel aborts.
module morse_encoder import morse_pkg::*; #(
    parameter int UNIT_CYCLES = 25000000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [4:0] letter,
    input  logic       cancel,
    output logic       ready,
    output logic       morse_out,
    output logic       sym_dot,
    output logic       sym_line,
    output logic       done
);

    logic [2:0]   state_q, state_d;
    logic [3:0]   sh_q;
    logic [2:0]   cnt_q;
    logic         first_q;
    letter_code_t code;
    logic [3:0]   first_pat;
    logic         accept;
    logic         tmr_load, tmr_long, tmr_clear, tmr_expire;

    // Left-align the pattern so the symbol being sent is always sh_q[3].
    always_comb begin
        code      = letter_code(letter);
        first_pat = code.pat << (3'd4 - code.len);
        accept    = (state_q == S_IDLE) && start && (letter <= LETTER_MAX);
        tmr_clear = cancel && (state_q != S_IDLE);
    end

    morse_unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (
        .clock     (clock),
        .resetn    (resetn),
        .load      (tmr_load),
        .long_unit (tmr_long),
        .clear     (tmr_clear),
        .expire    (tmr_expire)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_long = 1'b0;
        case (state_q)
            S_IDLE: if (accept) begin
                state_d  = S_MARK;
                tmr_load = 1'b1;
                tmr_long = first_pat[3];
            end
            S_MARK: if (tmr_expire) begin
                tmr_load = 1'b1;
                if (cnt_q > 3'd1) begin
                    state_d = S_GAP;
                end else begin
                    state_d  = S_LGAP;
                    tmr_long = 1'b1;
                end
            end
            S_GAP: if (tmr_expire) begin
                state_d  = S_MARK;
                tmr_load = 1'b1;
                tmr_long = sh_q[3];
            end
            S_LGAP: if (tmr_expire) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (tmr_clear) begin
            state_d  = S_IDLE;
            tmr_load = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn || tmr_clear) begin
            sh_q    <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
        end else begin
            first_q <= (state_d == S_MARK) && (state_q != S_MARK);
            if (accept) begin
                sh_q  <= first_pat;
                cnt_q <= code.len;
            end else if ((state_q == S_MARK) && tmr_expire) begin
                sh_q <= sh_q << 1;
                if (cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;
            end
        end
    end

    always_comb begin
        ready     = (state_q == S_IDLE);
        morse_out = (state_q == S_MARK);
        done      = (state_q == S_DONE);
        sym_dot   = morse_out && first_q && (sh_q[3] == SYM_DOT);
        sym_line  = morse_out && first_q && (sh_q[3] == SYM_LINE);
    end

endmodule

// File: tb/tb_morse_encoder.sv
// Bench for morse_encoder with UNIT_CYCLES=4: table vectors, random letters
// against a string-based timing model, plus start/cancel/reset corner sequences.
module tb_morse_encoder;

    localparam int UNIT = 4;

    logic       clock = 1'b0;
    logic       resetn, start, cancel;
    logic [4:0] letter;
    logic       ready, morse_out, sym_dot, sym_line, done;

    int checks = 0;
    int errors = 0;

    logic [4:0] exp_wave [0:255];
    int         exp_n;

    typedef struct {
        logic [4:0] letter;
        int         done_cyc;
        int         dots;
        int         lines;
    } vec_t;

    vec_t vecs [5];

    always #5 clock = ~clock;

    morse_encoder #(.UNIT_CYCLES(UNIT)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .letter    (letter),
        .cancel    (cancel),
        .ready     (ready),
        .morse_out (morse_out),
        .sym_dot   (sym_dot),
        .sym_line  (sym_line),
        .done      (done)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [4:0] obs();
        return {ready, morse_out, sym_dot, sym_line, done};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic string morse_of(input int l);
        case (l)
            0: return ".-";    1: return "-...";  2: return "-.-.";  3: return "-..";
            4: return ".";     5: return "..-.";  6: return "--.";   7: return "....";
            8: return "..";    9: return ".---"; 10: return "-.-";  11: return ".-..";
           12: return "--";   13: return "-.";   14: return "---";  15: return ".--.";
           16: return "--.-"; 17: return ".-.";  18: return "...";  19: return "-";
           20: return "..-";  21: return "...-"; 22: return ".--";  23: return "-..-";
           24: return "-.--"; 25: return "--..";
            default: return "";
        endcase
    endfunction

    // Expected {ready,morse_out,sym_dot,sym_line,done} for cycles 1..exp_n after accept.
    task automatic build_model(input int l);
        string s;
        int    c, mlen, glen;
        logic  is_line;
        s = morse_of(l);
        c = 1;
        for (int i = 0; i < s.len(); i++) begin
            is_line = (s[i] == "-");
            mlen = is_line ? 3 * UNIT : UNIT;
            for (int k = 0; k < mlen; k++) begin
                exp_wave[c] = {1'b0, 1'b1, (k == 0) && !is_line, (k == 0) && is_line, 1'b0};
                c++;
            end
            glen = (i == s.len() - 1) ? 3 * UNIT : UNIT;
            for (int k = 0; k < glen; k++) begin
                exp_wave[c] = 5'b00000;
                c++;
            end
        end
        exp_wave[c] = 5'b00001;
        c++;
        exp_wave[c] = 5'b10000;
        exp_n = c;
    endtask

    // Accept letter l, then follow the model; ign_cyc>0 pulses a stray start(E) in that cycle.
    task automatic send_and_watch(input logic [4:0] l, input int ign_cyc,
                                  output int done_cyc, output int dots,
                                  output int lines, output int werr);
        done_cyc = 0; dots = 0; lines = 0; werr = 0;
        start = 1'b1; letter = l; cancel = 1'b0;
        tick();
        start = 1'b0;
        build_model(int'(l));
        for (int c = 1; c <= exp_n; c++) begin
            if (obs() !== exp_wave[c]) werr++;
            if (done === 1'b1 && done_cyc == 0) done_cyc = c;
            if (sym_dot === 1'b1) dots++;
            if (sym_line === 1'b1) lines++;
            if (c == ign_cyc) begin
                start = 1'b1; letter = 5'd4;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        int dc, nd, nl, we, bad, l, idle, waited;

        resetn = 1'b0; start = 1'b0; cancel = 1'b0; letter = 5'd0;
        tick();
        tick();
        check("reset_outputs", 32'(obs()), 32'(5'b10000));
        resetn = 1'b1;
        tick();

        vecs[0] = '{letter: 5'd0,  done_cyc: 33, dots: 1, lines: 1};
        vecs[1] = '{letter: 5'd4,  done_cyc: 17, dots: 1, lines: 0};
        vecs[2] = '{letter: 5'd19, done_cyc: 25, dots: 0, lines: 1};
        vecs[3] = '{letter: 5'd25, done_cyc: 57, dots: 2, lines: 2};
        vecs[4] = '{letter: 5'd16, done_cyc: 65, dots: 1, lines: 3};

        for (int i = 0; i < 5; i++) begin
            send_and_watch(vecs[i].letter, 0, dc, nd, nl, we);
            check("vec_done_cycle", dc, vecs[i].done_cyc);
            check("vec_dots", nd, vecs[i].dots);
            check("vec_lines", nl, vecs[i].lines);
            check("vec_wave_errors", we, 0);
        end

        // Invalid letters: nothing may happen for 50 cycles.
        bad = 0;
        start = 1'b1; letter = 5'd26;
        if (obs() !== 5'b10000) bad++;
        tick();
        letter = 5'd31;
        if (obs() !== 5'b10000) bad++;
        tick();
        start = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (obs() !== 5'b10000) bad++;
            tick();
        end
        check("invalid_letter_idle", bad, 0);

        // Stray start during A is dropped.
        send_and_watch(5'd0, 10, dc, nd, nl, we);
        check("busy_start_wave", we, 0);
        check("busy_start_done", dc, 33);

        // Cancel sampled at edge 12 of an A.
        build_model(0);
        start = 1'b1; letter = 5'd0;
        tick();
        start = 1'b0;
        we = 0; bad = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c <= 12) begin
                if (obs() !== exp_wave[c]) we++;
            end else begin
                if (obs() !== 5'b10000) bad++;
            end
            cancel = (c == 12);
            tick();
        end
        cancel = 1'b0;
        check("cancel_pre_wave", we, 0);
        check("cancel_post_idle", bad, 0);

        // Start and cancel together in idle: start wins.
        start = 1'b1; cancel = 1'b1; letter = 5'd4;
        tick();
        start = 1'b0; cancel = 1'b0;
        check("start_beats_cancel", 32'(obs()), 32'(5'b01100));
        waited = 0;
        while (ready !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        check("start_cancel_returns_idle", 32'(ready), 32'd1);

        // Reset in cycle 15 of a Z, then a clean E.
        start = 1'b1; letter = 5'd25;
        tick();
        start = 1'b0;
        for (int c = 1; c < 15; c++) tick();
        check("z_in_gap_before_reset", 32'(obs()), 32'(5'b00000));
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("reset_mid_letter", 32'(obs()), 32'(5'b10000));
        tick();
        check("reset_stays_idle", 32'(obs()), 32'(5'b10000));
        send_and_watch(5'd4, 0, dc, nd, nl, we);
        check("post_reset_e_done", dc, 17);
        check("post_reset_e_wave", we, 0);

        // Random valid letters with random idle spacing.
        for (int r = 0; r < 16; r++) begin
            l = int'($urandom_range(0, 25));
            idle = int'($urandom_range(0, 3));
            for (int k = 0; k < idle; k++) tick();
            send_and_watch(5'(l), 0, dc, nd, nl, we);
            check("rand_wave", we, 0);
            check("rand_done_seen", 32'(dc != 0), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
